// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the two-master bus arbiter.
package bus_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_e;

    typedef enum logic {
        ARB_M0 = 1'b0,
        ARB_M1 = 1'b1
    } arb_owner_e;

    localparam int ARB_DEFAULT_TIMEOUT = 255;

    // Bits needed to hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Bundle of both requester channels and the shared slave bus.
// 'master' is the arbiter's view; 'slave' is the view of the requesters plus memory.
interface bus_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
    logic [ADDR_WIDTH-1:0]   m0_addr;
    logic [DATA_WIDTH-1:0]   m0_wdata, m0_rdata;
    logic [DATA_WIDTH/8-1:0] m0_be;

    logic                    m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
    logic [ADDR_WIDTH-1:0]   m1_addr;
    logic [DATA_WIDTH-1:0]   m1_wdata, m1_rdata;
    logic [DATA_WIDTH/8-1:0] m1_be;

    logic                    s_req, s_we, s_gnt, s_rvalid;
    logic [ADDR_WIDTH-1:0]   s_addr;
    logic [DATA_WIDTH-1:0]   s_wdata, s_rdata;
    logic [DATA_WIDTH/8-1:0] s_be;

    modport master (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_be,
        output m0_gnt, m0_rvalid, m0_rdata, m0_err,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_be,
        output m1_gnt, m1_rvalid, m1_rdata, m1_err,
        output s_req, s_we, s_addr, s_wdata, s_be,
        input  s_gnt, s_rvalid, s_rdata
    );

    modport slave (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_be,
        input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_be,
        input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
        input  s_req, s_we, s_addr, s_wdata, s_be,
        output s_gnt, s_rvalid, s_rdata
    );
endinterface

// File: rtl/bus_arbiter_prio_sel.sv
// Winner select: master 1 by default, master 0 when alone or after STARVE_LIMIT
// consecutive losses while it was requesting.
module arb_prio_sel
    import bus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       m0_req_i,
    input  logic       m1_req_i,
    input  logic       accept_i,
    output arb_owner_e winner_o
);
    localparam int SW = cnt_width(STARVE_LIMIT);

    logic [SW-1:0] starve_q, starve_d;
    logic          forced;

    assign forced = m0_req_i && (starve_q == SW'(STARVE_LIMIT));

    always_comb begin
        winner_o = ((m0_req_i && !m1_req_i) || forced) ? ARB_M0 : ARB_M1;
    end

    always_comb begin
        starve_d = starve_q;
        if (accept_i) begin
            if (winner_o == ARB_M0) begin
                starve_d = '0;
            end else if (m0_req_i && (starve_q != SW'(STARVE_LIMIT))) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
endmodule

// File: rtl/bus_arbiter.sv
// Two-master, single-outstanding bus arbiter with anti-starvation for master 0
// and a response timeout that returns an error to the owner.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = ARB_DEFAULT_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_n,
    bus_arbiter_if.master      bus,
    output arb_state_e         state_o
);
    localparam int TW = cnt_width(TIMEOUT);

    arb_state_e    state_q;
    arb_owner_e    owner_q;
    logic [TW-1:0] to_cnt_q;

    arb_owner_e              winner;
    logic                    idle, any_req, accept, sel_m1;
    logic                    to_last, resp_done, timed_out;
    logic [ADDR_WIDTH-1:0]   win_addr;
    logic [DATA_WIDTH-1:0]   resp_data;

    assign idle    = (state_q == ARB_IDLE);
    assign any_req = bus.m0_req || bus.m1_req;
    // Outputs are gated by rst_n so they drop the moment reset asserts.
    assign accept  = rst_n && idle && any_req && bus.s_gnt;
    assign sel_m1  = (winner == ARB_M1) && bus.m1_req;

    arb_prio_sel #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio_sel (
        .clk      (clk),
        .rst_n    (rst_n),
        .m0_req_i (bus.m0_req),
        .m1_req_i (bus.m1_req),
        .accept_i (accept),
        .winner_o (winner)
    );

    always_comb begin
        win_addr    = sel_m1 ? bus.m1_addr  : bus.m0_addr;
        bus.s_we    = sel_m1 ? bus.m1_we    : bus.m0_we;
        bus.s_wdata = sel_m1 ? bus.m1_wdata : bus.m0_wdata;
        bus.s_be    = sel_m1 ? bus.m1_be    : bus.m0_be;
    end

    assign bus.s_addr = win_addr;
    assign bus.s_req  = rst_n && idle && any_req;
    assign bus.m0_gnt = accept && !sel_m1;
    assign bus.m1_gnt = accept && sel_m1;

    assign to_last   = (to_cnt_q == TW'(TIMEOUT - 1));
    assign resp_done = !idle && (bus.s_rvalid || to_last);
    assign timed_out = !idle && !bus.s_rvalid && to_last;
    assign resp_data = bus.s_rvalid ? bus.s_rdata : '0;

    assign bus.m0_rvalid = resp_done && (owner_q == ARB_M0);
    assign bus.m1_rvalid = resp_done && (owner_q == ARB_M1);
    assign bus.m0_rdata  = bus.m0_rvalid ? resp_data : '0;
    assign bus.m1_rdata  = bus.m1_rvalid ? resp_data : '0;
    assign bus.m0_err    = bus.m0_rvalid && timed_out;
    assign bus.m1_err    = bus.m1_rvalid && timed_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            owner_q  <= ARB_M0;
            to_cnt_q <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (accept) begin
                        owner_q  <= winner;
                        to_cnt_q <= '0;
                        state_q  <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (bus.s_rvalid || to_last) begin
                        state_q <= ARB_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign state_o = state_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with a response scoreboard.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic       clk;
    logic       rst_n;
    arb_state_e state;

    int n_cmp = 0;
    int n_err = 0;

    // {valid, owner, err, rdata}
    logic [DW+2:0] exp_q[$];

    bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    bus_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .STARVE_LIMIT (4),
        .TIMEOUT      (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.master),
        .state_o (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic push_resp(input logic owner, input logic err, input logic [DW-1:0] data);
        exp_q.push_back({1'b1, owner, err, data});
    endtask

    task automatic collect(input string tag);
        logic [DW+2:0] obs;
        logic [DW+2:0] exp;
        if (bus.m0_rvalid)      obs = {1'b1, 1'b0, bus.m0_err, bus.m0_rdata};
        else if (bus.m1_rvalid) obs = {1'b1, 1'b1, bus.m1_err, bus.m1_rdata};
        else                    obs = '0;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
        chk({tag, "_both"}, {62'd0, bus.m0_rvalid, bus.m1_rvalid} == 64'd3, 64'd0);
    endtask

    logic [DW-1:0] d;
    logic          exp_win [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        rst_n = 1'b0;
        bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_be = '0;
        bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_be = '0;
        bus.s_gnt = 0; bus.s_rvalid = 0; bus.s_rdata = '0;

        // Reset: even with requests and s_gnt present, outputs stay low.
        step();
        bus.m0_req = 1; bus.m1_req = 1; bus.s_gnt = 1;
        #1;
        chk("rst_m0_gnt", bus.m0_gnt, 0);
        chk("rst_m1_gnt", bus.m1_gnt, 0);
        chk("rst_s_req", bus.s_req, 0);
        chk("rst_rvalid", {bus.m0_rvalid, bus.m1_rvalid}, 0);
        chk("rst_err", {bus.m0_err, bus.m1_err}, 0);
        chk("rst_rdata", {bus.m0_rdata, bus.m1_rdata}, 0);
        chk("rst_state", state, ARB_IDLE);
        bus.m0_req = 0; bus.m1_req = 0; bus.s_gnt = 0;
        step();
        rst_n = 1'b1;

        // Single master 0 read.
        step();
        bus.m0_req = 1; bus.m0_addr = 32'h100; bus.s_gnt = 1;
        #1;
        chk("t1_m0_gnt", bus.m0_gnt, 1);
        chk("t1_m1_gnt", bus.m1_gnt, 0);
        chk("t1_s_req", bus.s_req, 1);
        chk("t1_s_addr", bus.s_addr, 32'h100);
        chk("t1_s_we", bus.s_we, 0);
        step();
        bus.m0_req = 0; bus.s_gnt = 0; bus.s_rvalid = 1; bus.s_rdata = 32'hDEADBEEF;
        push_resp(1'b0, 1'b0, 32'hDEADBEEF);
        #1;
        collect("t1_resp");
        chk("t1_m0_gnt_off", bus.m0_gnt, 0);
        chk("t1_m1_out", {bus.m1_rvalid, bus.m1_err, bus.m1_rdata}, 0);
        step();
        bus.s_rvalid = 0;
        #1;
        chk("t1_idle", state, ARB_IDLE);
        chk("t1_no_rvalid", bus.m0_rvalid, 0);

        // Both requesting, slave always ready: m1 wins 4 times, then m0 is forced.
        for (int i = 0; i < 6; i++) begin
            step();
            bus.s_rvalid = 0;
            bus.m0_req = 1; bus.m1_req = 1; bus.s_gnt = 1;
            bus.m0_addr = 32'h200; bus.m1_addr = 32'h300 + i;
            #1;
            chk($sformatf("t2_m0_gnt_%0d", i), bus.m0_gnt, !exp_win[i]);
            chk($sformatf("t2_m1_gnt_%0d", i), bus.m1_gnt, exp_win[i]);
            chk($sformatf("t2_addr_%0d", i), bus.s_addr, exp_win[i] ? 32'h300 + i : 32'h200);
            step();
            d = $urandom;
            bus.s_rvalid = 1; bus.s_rdata = d;
            push_resp(exp_win[i], 1'b0, d);
            #1;
            collect($sformatf("t2_resp_%0d", i));
            chk($sformatf("t2_wait_gnt_%0d", i), {bus.m0_gnt, bus.m1_gnt}, 0);
        end
        step();
        bus.s_rvalid = 0; bus.m0_req = 0; bus.m1_req = 0; bus.s_gnt = 0;

        // Master 1 write with slave grant delayed 3 cycles.
        step();
        bus.m1_req = 1; bus.m1_we = 1; bus.m1_be = 4'b0011; bus.m1_wdata = 32'h1234;
        bus.m1_addr = 32'h400;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) bus.s_gnt = 1;
            #1;
            chk($sformatf("t3_s_req_%0d", k), bus.s_req, 1);
            chk($sformatf("t3_fields_%0d", k), {bus.s_we, bus.s_be, bus.s_wdata},
                {1'b1, 4'b0011, 32'h1234});
            chk($sformatf("t3_addr_%0d", k), bus.s_addr, 32'h400);
            chk($sformatf("t3_m1_gnt_%0d", k), bus.m1_gnt, (k == 3) ? 1 : 0);
            if (k < 3) step();
        end
        step();
        bus.m1_req = 0; bus.m1_we = 0; bus.s_gnt = 0;
        bus.s_rvalid = 1; bus.s_rdata = 32'h55;
        push_resp(1'b1, 1'b0, 32'h55);
        #1;
        collect("t3_resp");
        step();
        bus.s_rvalid = 0;

        // Timeout: grant m0, never respond; error 8 cycles after the grant.
        step();
        bus.m0_req = 1; bus.m0_addr = 32'h500; bus.s_gnt = 1; bus.s_rdata = 32'hAAAA5555;
        #1;
        chk("t4_m0_gnt", bus.m0_gnt, 1);
        for (int k = 1; k < 8; k++) begin
            step();
            if (k == 1) begin
                bus.m0_req = 0; bus.s_gnt = 0;
            end
            #1;
            chk($sformatf("t4_quiet_%0d", k), {bus.m0_rvalid, bus.m1_rvalid}, 0);
        end
        step();
        push_resp(1'b0, 1'b1, '0);
        #1;
        collect("t4_timeout");
        step();
        #1;
        chk("t4_idle", state, ARB_IDLE);
        bus.s_rvalid = 1;
        #1;
        chk("t4_stray", {bus.m0_rvalid, bus.m1_rvalid}, 0);
        step();
        bus.s_rvalid = 0;

        // Reset asserted between edges while WAITing on master 1.
        step();
        bus.m1_req = 1; bus.m1_addr = 32'h600; bus.s_gnt = 1;
        #1;
        chk("t5_m1_gnt", bus.m1_gnt, 1);
        step();
        bus.m1_req = 0; bus.s_gnt = 0;
        #1;
        chk("t5_wait", state, ARB_WAIT);
        #2;
        rst_n = 1'b0; bus.s_rvalid = 1; bus.s_rdata = 32'h77;
        #1;
        chk("t5_rst_state", state, ARB_IDLE);
        chk("t5_rst_rvalid", {bus.m0_rvalid, bus.m1_rvalid}, 0);
        chk("t5_rst_rdata", bus.m1_rdata, 0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("t5_post_rvalid", {bus.m0_rvalid, bus.m1_rvalid}, 0);
        step();
        bus.s_rvalid = 0;
        #1;
        chk("t5_post_idle", state, ARB_IDLE);

        // Back-to-back: m0 response and new m1 request in the same cycle.
        step();
        bus.m0_req = 1; bus.m0_addr = 32'h700; bus.s_gnt = 1;
        #1;
        chk("t6_m0_gnt", bus.m0_gnt, 1);
        step();
        bus.m0_req = 0; bus.m1_req = 1; bus.m1_addr = 32'h800;
        bus.s_rvalid = 1; bus.s_rdata = 32'h11112222;
        push_resp(1'b0, 1'b0, 32'h11112222);
        #1;
        collect("t6_m0_resp");
        chk("t6_m1_gnt_early", bus.m1_gnt, 0);
        step();
        bus.s_rvalid = 0;
        #1;
        chk("t6_m1_gnt", bus.m1_gnt, 1);
        chk("t6_s_addr", bus.s_addr, 32'h800);
        step();
        bus.m1_req = 0; bus.s_gnt = 0; bus.s_rvalid = 1; bus.s_rdata = 32'h3333;
        push_resp(1'b1, 1'b0, 32'h3333);
        #1;
        collect("t6_m1_resp");
        step();
        bus.s_rvalid = 0;
        #1;
        chk("sb_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares one single-port memory/peripheral bus between two requesters: master 0 (instruction fetch) and master 1 (load/store unit).
- Arbitrates requests and tracks the single outstanding transaction.
- Routes the response back to the owning master.
- Applies anti-starvation for master 0 and a response timeout.
- Sits between the core's fetch/LSU front ends and the memory slave.

Parameters:
- ADDR_WIDTH, 32, address width (matches `CPU_WIDTH).
- DATA_WIDTH, 32, data width (matches `CPU_WIDTH).
- STARVE_LIMIT, 4, consecutive lost arbitrations by master 0 before it is forced to win.
- TIMEOUT, 255, maximum cycles in WAIT before an error response is generated.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m0_req  in  1  master 0 request.
- m0_we  in  1  master 0 write enable.
- m0_addr  in  ADDR_WIDTH  master 0 address.
- m0_wdata  in  DATA_WIDTH  master 0 write data.
- m0_be  in  DATA_WIDTH/8  master 0 byte enables.
- m0_gnt  out  1  master 0 request accepted.
- m0_rvalid  out  1  master 0 response valid.
- m0_rdata  out  DATA_WIDTH  master 0 read data.
- m0_err  out  1  master 0 timeout error.
- m1_req, m1_we, m1_addr, m1_wdata, m1_be, m1_gnt, m1_rvalid, m1_rdata, m1_err: same as master 0, for master 1.
- s_req  out  1  slave request.
- s_we  out  1  slave write enable.
- s_addr  out  ADDR_WIDTH  slave address.
- s_wdata  out  DATA_WIDTH  slave write data.
- s_be  out  DATA_WIDTH/8  slave byte enables.
- s_gnt  in  1  slave accepted request.
- s_rvalid  in  1  slave response valid.
- s_rdata  in  DATA_WIDTH  slave read data.

Behaviour:
- Reset is asynchronous, active-low, and applies to all state.
  - state=IDLE, owner=0, starve_cnt=0, to_cnt=0.
  - All gnt, rvalid, err and s_req outputs are 0; rdata outputs are 0.
- Reset mid-transaction aborts it: no rvalid is issued to either master afterwards.
- States: IDLE, WAIT.
- IDLE:
  - Winner select is combinational.
    - Master 1 wins by default.
    - Master 0 wins when only m0_req is set, or when starve_cnt==STARVE_LIMIT.
  - s_req = m0_req|m1_req.
  - s_we, s_addr, s_wdata, s_be are muxed from the winner. When there is no request they are driven from master 0 and are don't-care.
  - If s_gnt is high in the same cycle:
    - Winner's gnt=1 for that cycle only.
    - owner <= winner, to_cnt <= 0, state <= WAIT.
  - The loser's gnt stays 0; the loser must hold its request stable until granted.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on each accepted grant to master 1 while m0_req is high.
  - Clears on any grant to master 0.
- WAIT:
  - s_req=0; no new grants.
  - s_rvalid forwards to the owner in the same cycle: owner_rvalid=1, owner_rdata=s_rdata, err=0; state <= IDLE.
  - Otherwise to_cnt increments.
  - If to_cnt==TIMEOUT-1 and s_rvalid=0: owner_rvalid=1, owner_err=1, rdata=0; state <= IDLE.
- s_rvalid arriving in IDLE (a late response after timeout) is dropped: no master rvalid.
- Non-owner rvalid, rdata and err are always 0.
- Throughput:
  - At most one outstanding transaction.
  - The minimum cycle from grant to next grant is 2 (grant cycle, then response cycle).
  - The next grant is possible in the cycle after rvalid.
- Zero-wait slave: s_rvalid in the cycle after grant gives a 1-cycle request-to-response latency.

Decomposition:
- Shared defines in rvseed_defines.v: ARB_IDLE/ARB_WAIT state encodings, ARB_M0/ARB_M1 owner IDs, and a default-timeout constant.
- One sub-module, arb_prio_sel: combinational winner select plus the saturating starve_cnt register, with inputs m0_req, m1_req, accept.
- The FSM, timeout counter and response routing stay in bus_arbiter.

Test Plan:
- Single master 0 read:
  - m0_req, addr=0x100; s_gnt=1 the same cycle; s_rvalid with data 0xDEADBEEF the next cycle.
  - Expect m0_gnt for 1 cycle, then m0_rvalid=1, m0_rdata=0xDEADBEEF, m0_err=0; m1 outputs stay 0.
- Simultaneous requests, slave always ready, 1-cycle response:
  - Expect master 1 granted first.
  - With both held requesting, master 1 wins 4 times, then master 0 is forced to win on the 5th grant, and starve_cnt clears.
- Master 1 write:
  - we=1, be=4'b0011, wdata=0x1234; s_gnt delayed 3 cycles.
  - Expect s_req held with stable fields; m1_gnt only in the s_gnt cycle.
- Timeout with TIMEOUT=8:
  - Grant master 0, never assert s_rvalid.
  - Expect m0_rvalid=1, m0_err=1, m0_rdata=0 exactly 8 cycles after grant; return to IDLE.
  - A later stray s_rvalid produces no master rvalid.
- Reset mid-WAIT:
  - Assert rst_n=0 asynchronously between clock edges.
  - Expect outputs 0 immediately; after release, the state is IDLE and no pending rvalid is delivered.
- Back-to-back:
  - Master 0 response and a new m1_req in the same cycle.
  - Expect the m1 grant no earlier than the following cycle.
